core_fetch: RTL



---
 rtl/core_fetch.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/core_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word requests, 2-entry queue to decode.
// Optional JAL predecode redirect is enabled by defining CORE_FETCH_JAL_PREDECODE_EN.
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_ibus_req,
  output logic [31:0] o_ibus_addr,
  input  logic        i_ibus_gnt,
  input  logic        i_ibus_rvalid,
  input  logic [31:0] i_ibus_rdata,
  input  logic        i_branch_jalr,
  input  logic [31:0] i_branch_jalr_target,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  if (QDEPTH != 2) begin : g_qdepth_check
    $error("core_fetch supports QDEPTH == 2 only");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        stale;
  logic [1:0]  count;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];

  logic [31:0] redirect_pc;
  logic [31:0] pc_next;
  logic [1:0]  count_next;
  logic        push;
  logic        pop;
  logic        wr_hi;

  assign redirect_pc = i_branch_jalr_target & ~32'd1;
  // A response is kept only if it belongs to the current path and no redirect lands on the same edge.
  assign push        = (state == WAIT) && i_ibus_rvalid && !stale && !i_branch_jalr;
  assign pop         = o_valid && i_ready;
  assign wr_hi       = pop ? (count == 2'd2) : (count == 2'd1);
  assign count_next  = i_branch_jalr ? 2'd0 : (count + 2'(push) - 2'(pop));

`ifdef CORE_FETCH_JAL_PREDECODE_EN
  logic        is_jal;
  logic [31:0] jal_target;
  assign is_jal     = (i_ibus_rdata[6:0] == 7'b1101111);
  assign jal_target = req_pc + {{12{i_ibus_rdata[31]}}, i_ibus_rdata[19:12],
                                i_ibus_rdata[20], i_ibus_rdata[30:21], 1'b0};
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_next = pc;
    if (state == REQ && i_ibus_gnt && !stale) pc_next = pc + 32'd4;
`ifdef CORE_FETCH_JAL_PREDECODE_EN
    if (push && is_jal) pc_next = jal_target;
`endif
    if (i_branch_jalr) pc_next = redirect_pc;
  end

  assign o_valid = (count != 2'd0);
  assign o_instr = q_instr[0];
  assign o_pc    = q_pc[0];

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      req_pc      <= 32'd0;
      stale       <= 1'b0;
      count       <= 2'd0;
      o_ibus_req  <= 1'b0;
      o_ibus_addr <= 32'd0;
      // NOTE: queue storage is only two words and is reset so o_instr/o_pc read 0 out of reset.
      for (int i = 0; i < 2; i++) begin
        q_pc[i]    <= 32'd0;
        q_instr[i] <= 32'd0;
      end
    end else begin
      pc    <= pc_next;
      count <= count_next;

      if (pop) begin
        q_pc[0]    <= q_pc[1];
        q_instr[0] <= q_instr[1];
      end
      if (push) begin
        if (wr_hi) begin
          q_pc[1]    <= req_pc;
          q_instr[1] <= i_ibus_rdata;
        end else begin
          q_pc[0]    <= req_pc;
          q_instr[0] <= i_ibus_rdata;
        end
      end

      case (state)
        IDLE: begin
          if (count_next < 2'd2) begin
            state       <= REQ;
            o_ibus_req  <= 1'b1;
            o_ibus_addr <= {pc_next[31:2], 2'b00};
          end
        end
        REQ: begin
          // A redirect before or at the grant turns the in-flight request into wrong-path data.
          if (i_branch_jalr) stale <= 1'b1;
          if (i_ibus_gnt) begin
            state      <= WAIT;
            o_ibus_req <= 1'b0;
            req_pc     <= pc;
          end
        end
        WAIT: begin
          if (i_ibus_rvalid) begin
            stale <= 1'b0;
            if (count_next < 2'd2) begin
              state       <= REQ;
              o_ibus_req  <= 1'b1;
              o_ibus_addr <= {pc_next[31:2], 2'b00};
            end else begin
              state <= IDLE;
            end
          end else if (i_branch_jalr) begin
            stale <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && count == 2'd2 && !pop)) else $error("core_fetch queue overflow");
  end

endmodule
